// File: rtl/wb_ram_slave_if.sv
// Wishbone B4 pipelined bus between one master and the RAM responder.
// Signal names follow the slave's point of view (_i into the slave, _o out of it).
interface wb_ram_slave_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic        wb_stb_i;
    logic        wb_ack_o;
    logic        wb_cyc_i;
    logic        wb_stall_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o, wb_stall_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o, wb_stall_o
    );
endinterface

// File: rtl/wb_ram_slave.sv
// Pipelined Wishbone B4 word RAM; in-order ack LATENCY edges after acceptance (1..4).
// Backpressure: hold_i stalls acceptance and freezes the ack pipeline in place.
module wb_ram_slave #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              hold_i,
    wb_ram_slave_if.slave     wb
);

    typedef struct packed {
        logic        vld;
        logic        we;
        logic [31:0] rdat;
    } stage_t;

    logic [31:0]           mem [0:(1 << ADDR_WIDTH) - 1];
    stage_t                pipe_q [LATENCY];
    stage_t                last_q;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  req_vld;
    logic                  ack_vld;
    logic                  unused_adr_bits;

    // Only the word index matters; byte offset and upper bits alias.
    assign word_idx        = wb.wb_adr_i[ADDR_WIDTH+1:2];
    assign unused_adr_bits = ^{wb.wb_adr_i[31:ADDR_WIDTH+2], wb.wb_adr_i[1:0]};

    assign wb.wb_stall_o = hold_i;
    assign req_vld       = wb.wb_cyc_i & wb.wb_stb_i & ~hold_i & ~rst_i;

    always_ff @(posedge clk_i) begin
        if (req_vld && wb.wb_we_i) begin
            for (int k = 0; k < 4; k++) begin
                if (wb.wb_sel_i[k]) begin
                    mem[word_idx][8*k +: 8] <= wb.wb_dat_i[8*k +: 8];
                end
            end
        end
    end

    // Reset and cycle abort both drop every outstanding ack; only valid bits need clearing.
    always_ff @(posedge clk_i) begin
        if (rst_i || !wb.wb_cyc_i) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i].vld <= 1'b0;
            end
        end else if (!hold_i) begin
            pipe_q[0].vld  <= req_vld;
            pipe_q[0].we   <= wb.wb_we_i;
            pipe_q[0].rdat <= mem[word_idx];
            for (int i = 1; i < LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign last_q      = pipe_q[LATENCY-1];
    assign ack_vld     = last_q.vld & ~hold_i & wb.wb_cyc_i;
    assign wb.wb_ack_o = ack_vld;
    assign wb.wb_dat_o = (ack_vld && !last_q.we) ? last_q.rdat : 32'h0;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Directed bench for wb_ram_slave: LATENCY=2 is the main target, LATENCY=1 and 4
// copies share the same stimulus and are checked during the latency sweep.
module tb_wb_ram_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hold = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [31:0] adr = 32'h0;
    logic [31:0] wdat = 32'h0;
    logic [3:0]  sel = 4'h0;

    int          n_chk = 0;
    int          n_fail = 0;
    string       scen = "init";
    int          cnum = 0;
    logic        sweep = 1'b0;
    logic [31:0] sw_d1 = 32'h0;
    logic [31:0] sw_d4 = 32'h0;

    always #5 clk = ~clk;

    wb_ram_slave_if if1 ();
    wb_ram_slave_if if2 ();
    wb_ram_slave_if if4 ();

    assign if1.wb_adr_i = adr;  assign if2.wb_adr_i = adr;  assign if4.wb_adr_i = adr;
    assign if1.wb_dat_i = wdat; assign if2.wb_dat_i = wdat; assign if4.wb_dat_i = wdat;
    assign if1.wb_we_i  = we;   assign if2.wb_we_i  = we;   assign if4.wb_we_i  = we;
    assign if1.wb_sel_i = sel;  assign if2.wb_sel_i = sel;  assign if4.wb_sel_i = sel;
    assign if1.wb_stb_i = stb;  assign if2.wb_stb_i = stb;  assign if4.wb_stb_i = stb;
    assign if1.wb_cyc_i = cyc;  assign if2.wb_cyc_i = cyc;  assign if4.wb_cyc_i = cyc;

    wb_ram_slave #(.ADDR_WIDTH(10), .LATENCY(1)) u_dut1 (.clk_i(clk), .rst_i(rst), .hold_i(hold), .wb(if1.slave));
    wb_ram_slave #(.ADDR_WIDTH(10), .LATENCY(2)) u_dut2 (.clk_i(clk), .rst_i(rst), .hold_i(hold), .wb(if2.slave));
    wb_ram_slave #(.ADDR_WIDTH(10), .LATENCY(4)) u_dut4 (.clk_i(clk), .rst_i(rst), .hold_i(hold), .wb(if4.slave));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // One bus cycle: drive inputs, sample outputs of this cycle, advance past the edge.
    // ea = {ack L4, ack L2, ack L1}; ed = expected L2 data.
    task automatic step(input logic c, input logic s, input logic w,
                        input logic [31:0] a, input logic [31:0] d, input logic [3:0] sl,
                        input logic h, input logic r, input logic [2:0] ea, input logic [31:0] ed);
        cyc = c; stb = s; we = w; adr = a; wdat = d; sel = sl; hold = h; rst = r;
        #1;
        check($sformatf("%s c%0d ack", scen, cnum), {31'b0, if2.wb_ack_o}, {31'b0, ea[1]});
        check($sformatf("%s c%0d dat", scen, cnum), if2.wb_dat_o, ed);
        check($sformatf("%s c%0d stall", scen, cnum), {31'b0, if2.wb_stall_o}, {31'b0, h});
        if (sweep) begin
            check($sformatf("%s c%0d ack_l1", scen, cnum), {31'b0, if1.wb_ack_o}, {31'b0, ea[0]});
            check($sformatf("%s c%0d ack_l4", scen, cnum), {31'b0, if4.wb_ack_o}, {31'b0, ea[2]});
            check($sformatf("%s c%0d dat_l1", scen, cnum), if1.wb_dat_o, sw_d1);
            check($sformatf("%s c%0d dat_l4", scen, cnum), if4.wb_dat_o, sw_d4);
        end
        cnum++;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, input logic [2:0] ea, input logic [31:0] ed);
        step(1'b1, 1'b1, 1'b0, a, 32'h0, 4'hF, 1'b0, 1'b0, ea, ed);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] sl,
                      input logic [2:0] ea, input logic [31:0] ed);
        step(1'b1, 1'b1, 1'b1, a, d, sl, 1'b0, 1'b0, ea, ed);
    endtask

    task automatic nop(input logic [2:0] ea, input logic [31:0] ed);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, ea, ed);
    endtask

    // Bus idle between scenarios; cyc low also flushes all three pipelines.
    task automatic gap(input string next);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 3'b000, 32'h0);
        scen = next;
        cnum = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;

        scen = "reset";
        nop(3'b000, 32'h0);
        gap("sweep");

        // Write then read the same word; L1/L2/L4 ack positions differ.
        sweep = 1'b1;
        sw_d1 = 32'h0; sw_d4 = 32'h0;        wr(32'h10, 32'hDEADBEEF, 4'hF, 3'b000, 32'h0);
        sw_d1 = 32'h0; sw_d4 = 32'h0;        rd(32'h10, 3'b001, 32'h0);
        sw_d1 = 32'hDEADBEEF; sw_d4 = 32'h0; nop(3'b011, 32'h0);
        sw_d1 = 32'h0; sw_d4 = 32'h0;        nop(3'b010, 32'hDEADBEEF);
        sw_d1 = 32'h0; sw_d4 = 32'h0;        nop(3'b100, 32'h0);
        sw_d1 = 32'h0; sw_d4 = 32'hDEADBEEF; nop(3'b100, 32'h0);
        sw_d1 = 32'h0; sw_d4 = 32'h0;        nop(3'b000, 32'h0);
        sweep = 1'b0;
        gap("lanes");

        wr(32'h20, 32'h11223344, 4'hF, 3'b000, 32'h0);
        wr(32'h20, 32'hAABBCCDD, 4'b0101, 3'b000, 32'h0);
        rd(32'h20, 3'b010, 32'h0);
        wr(32'h20, 32'hFFFFFFFF, 4'b0000, 3'b010, 32'h0);
        rd(32'h20, 3'b010, 32'h11BB33DD);
        nop(3'b010, 32'h0);
        nop(3'b010, 32'h11BB33DD);
        nop(3'b000, 32'h0);
        gap("b2b");

        // Preload words 0..5 with 100..105, then read them back to back.
        for (int k = 0; k < 15; k++) begin
            logic        ea;
            logic [31:0] ed;
            ea = (k >= 2 && k < 14);
            ed = (k >= 8 && k < 14) ? 32'(100 + k - 8) : 32'h0;
            if (k < 6)       wr(32'(k * 4), 32'(100 + k), 4'hF, {1'b0, ea, 1'b0}, ed);
            else if (k < 12) rd(32'(4 * (k - 6)), {1'b0, ea, 1'b0}, ed);
            else             nop({1'b0, ea, 1'b0}, ed);
        end
        gap("hold");

        rd(32'h0, 3'b000, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF, 1'b1, 1'b0, 3'b000, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF, 1'b1, 1'b0, 3'b000, 32'h0);
        rd(32'h4, 3'b000, 32'h0);
        rd(32'h8, 3'b010, 32'd100);
        nop(3'b010, 32'd101);
        nop(3'b010, 32'd102);
        nop(3'b000, 32'h0);
        // Hold landing exactly on a due ack must suppress it for that cycle.
        rd(32'hC, 3'b000, 32'h0);
        nop(3'b000, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 3'b000, 32'h0);
        nop(3'b010, 32'd103);
        nop(3'b000, 32'h0);
        gap("abort");

        rd(32'h0, 3'b000, 32'h0);
        wr(32'h18, 32'h00000055, 4'hF, 3'b000, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF, 1'b0, 1'b0, 3'b000, 32'h0);
        nop(3'b000, 32'h0);
        nop(3'b000, 32'h0);
        nop(3'b000, 32'h0);
        rd(32'h18, 3'b000, 32'h0);
        nop(3'b000, 32'h0);
        nop(3'b010, 32'h00000055);
        nop(3'b000, 32'h0);
        gap("rst");

        wr(32'h1C, 32'hCAFEF00D, 4'hF, 3'b000, 32'h0);
        nop(3'b000, 32'h0);
        nop(3'b010, 32'h0);
        rd(32'h0, 3'b000, 32'h0);
        rd(32'h4, 3'b000, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 3'b010, 32'd100);
        nop(3'b000, 32'h0);
        nop(3'b000, 32'h0);
        rd(32'h1C, 3'b000, 32'h0);
        nop(3'b000, 32'h0);
        nop(3'b010, 32'hCAFEF00D);
        nop(3'b000, 32'h0);
        gap("alias");

        wr(32'h10, 32'h0BADF00D, 4'hF, 3'b000, 32'h0);
        rd(32'h00001010, 3'b000, 32'h0);
        rd(32'hFFFFF013, 3'b010, 32'h0);
        nop(3'b010, 32'h0BADF00D);
        nop(3'b010, 32'h0BADF00D);
        nop(3'b000, 32'h0);
        gap("done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
